// File: rtl/insn_queue_pkg.sv
// Shared front-end definitions for the instruction queue: widths, bundle type, mask popcount.
package mips_pkg;
    localparam int INSN_WIDTH  = 99;
    localparam int ISSUE_WIDTH = 2;
    localparam int FETCH_WIDTH = 4;

    typedef logic [INSN_WIDTH-1:0] insn_t;

    function automatic logic [2:0] popcount4(input logic [3:0] m);
        return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
    endfunction
endpackage

// File: rtl/insn_queue_if.sv
// Aligner/issue-side bundle for insn_queue; master = upstream + issue stage, slave = queue.
interface insn_queue_if #(
    parameter int INSN_WIDTH = mips_pkg::INSN_WIDTH,
    parameter int PTR_WIDTH  = 4
);
    logic                  i_flush;
    logic [3:0]            i_valid;
    logic [INSN_WIDTH-1:0] i_isn1;
    logic [INSN_WIDTH-1:0] i_isn2;
    logic [INSN_WIDTH-1:0] i_isn3;
    logic [INSN_WIDTH-1:0] i_isn4;
    logic                  o_full;
    logic [1:0]            o_valid;
    logic [INSN_WIDTH-1:0] o_isn1;
    logic [INSN_WIDTH-1:0] o_isn2;
    logic [1:0]            i_deq;
    logic [PTR_WIDTH:0]    o_count;

    modport master (
        output i_flush, i_valid, i_isn1, i_isn2, i_isn3, i_isn4, i_deq,
        input  o_full, o_valid, o_isn1, o_isn2, o_count
    );
    modport slave (
        input  i_flush, i_valid, i_isn1, i_isn2, i_isn3, i_isn4, i_deq,
        output o_full, o_valid, o_isn1, o_isn2, o_count
    );
endinterface

// File: rtl/insn_queue_compact.sv
// Packs the sparse fetch-group valid mask into contiguous slots, oldest first.
module insn_compact
    import mips_pkg::*;
#(
    parameter int INSN_WIDTH = mips_pkg::INSN_WIDTH
) (
    input  logic [FETCH_WIDTH-1:0]                 i_valid,
    input  logic [FETCH_WIDTH-1:0][INSN_WIDTH-1:0] i_isn,
    output logic [FETCH_WIDTH-1:0][INSN_WIDTH-1:0] o_slot,
    output logic [FETCH_WIDTH-1:0]                 o_slot_vld,
    output logic [2:0]                             o_nenq
);
    logic [2:0] pos;

    always_comb begin
        o_slot = '0;
        pos    = '0;
        for (int j = 0; j < FETCH_WIDTH; j++) begin
            if (i_valid[j]) begin
                o_slot[pos[1:0]] = i_isn[j];
                pos              = pos + 3'd1;
            end
        end
    end

    assign o_nenq = popcount4(i_valid);

    for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_slot_vld
        assign o_slot_vld[k] = o_nenq > 3'(k);
    end
endmodule

// File: rtl/insn_queue.sv
// In-order instruction queue: 4-wide compacting enqueue, 2-wide in-order dequeue, flush.
// Optional INSN_QUEUE_STATS_EN adds occupancy high-water mark and full-stall cycle counter.
module insn_queue
    import mips_pkg::*;
#(
    parameter int INSN_WIDTH = mips_pkg::INSN_WIDTH,
    parameter int DEPTH      = 16,                 // power of 2, >= 8
    parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
    input  logic        i_Clk,
    input  logic        i_Reset_n,
    insn_queue_if.slave q
`ifdef INSN_QUEUE_STATS_EN
    ,
    output logic [PTR_WIDTH:0] o_hwm,
    output logic [31:0]        o_full_cycles
`endif
);
    localparam logic [PTR_WIDTH:0] FULL_THR = (PTR_WIDTH+1)'(DEPTH - FETCH_WIDTH);

    logic [FETCH_WIDTH-1:0][INSN_WIDTH-1:0] in_isn, slot;
    logic [FETCH_WIDTH-1:0]                 slot_vld;
    logic [2:0]                             nenq;

    logic [INSN_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH-1:0]  head, tail, head_p1;
    logic [PTR_WIDTH:0]    count, count_next;
    logic                  full, enq_fire;
    logic [1:0]            vld, ndeq;

    assign in_isn = {q.i_isn4, q.i_isn3, q.i_isn2, q.i_isn1};

    insn_compact #(.INSN_WIDTH(INSN_WIDTH)) u_compact (
        .i_valid    (q.i_valid),
        .i_isn      (in_isn),
        .o_slot     (slot),
        .o_slot_vld (slot_vld),
        .o_nenq     (nenq)
    );

    // Gating uses the registered count only; slots freed this cycle are not reused until next.
    assign full     = count > FULL_THR;
    assign enq_fire = (|q.i_valid) && !full && !q.i_flush;

    assign vld[0] = count >= (PTR_WIDTH+1)'(1);
    assign vld[1] = count >= (PTR_WIDTH+1)'(2);
    // A lone i_deq[1] cannot retire head+1 ahead of head, so it counts as nothing.
    assign ndeq   = 2'(q.i_deq[0] & vld[0]) + 2'(q.i_deq[1] & q.i_deq[0] & vld[1]);

    assign count_next = count
                      + (enq_fire ? (PTR_WIDTH+1)'(nenq) : '0)
                      - (PTR_WIDTH+1)'(ndeq);

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (q.i_flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_WIDTH'(ndeq);
            tail  <= tail + (enq_fire ? PTR_WIDTH'(nenq) : '0);
            count <= count_next;
        end
    end

    always_ff @(posedge i_Clk) begin
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            if (enq_fire && slot_vld[k])
                mem[tail + PTR_WIDTH'(k)] <= slot[k];
        end
    end

    assign head_p1   = head + PTR_WIDTH'(1);
    assign q.o_isn1  = vld[0] ? mem[head]    : '0;
    assign q.o_isn2  = vld[1] ? mem[head_p1] : '0;
    assign q.o_valid = vld;
    assign q.o_full  = full;
    assign q.o_count = count;

`ifdef INSN_QUEUE_STATS_EN
    // Survives flush on purpose: it characterises the workload, not the current contents.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            o_hwm         <= '0;
            o_full_cycles <= '0;
        end else begin
            if (count > o_hwm)
                o_hwm <= count;
            if (full && (|q.i_valid) && (o_full_cycles != 32'hFFFF_FFFF))
                o_full_cycles <= o_full_cycles + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_insn_queue.sv
// Scoreboard bench for insn_queue: driver pushes expected entries, negedge monitor pops on dequeue.
module tb_insn_queue;
    import mips_pkg::*;

    localparam int W     = 99;
    localparam int DEPTH = 16;
    localparam int PW    = 4;
    typedef logic [W-1:0] word_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    insn_queue_if #(.INSN_WIDTH(W), .PTR_WIDTH(PW)) qif ();

`ifdef INSN_QUEUE_STATS_EN
    logic [PW:0] hwm;
    logic [31:0] fc;
`endif

    insn_queue #(.INSN_WIDTH(W), .DEPTH(DEPTH), .PTR_WIDTH(PW)) dut (
        .i_Clk     (clk),
        .i_Reset_n (rst_n),
        .q         (qif)
`ifdef INSN_QUEUE_STATS_EN
        ,
        .o_hwm         (hwm),
        .o_full_cycles (fc)
`endif
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    int    m_count = 0;
    bit    run     = 0;
    word_t exp_q[$];

    function automatic word_t mk(int n);
        return {3'b101, 32'(n) * 32'h9E37_79B9, 32'hC0DE_0000 | 32'(n), 32'(n)};
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pop_chk(string name, word_t act);
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got %0h expected <scoreboard empty>", name, act);
        end else begin
            chk(name, act, exp_q.pop_front());
        end
    endtask

    // One clock of stimulus; base selects isn1..isn4 = mk(base..base+3).
    task automatic step4(input logic [3:0] v, input int base, input logic [1:0] deq, input logic fl);
        bit acc;
        int nenq, ndeq;
        acc  = (v != 4'd0) && !fl && !(m_count > DEPTH - 4);
        nenq = 0;
        if (acc)
            for (int j = 0; j < 4; j++)
                if (v[j]) begin
                    exp_q.push_back(mk(base + j));
                    nenq++;
                end
        qif.i_valid = v;
        qif.i_isn1  = mk(base);
        qif.i_isn2  = mk(base + 1);
        qif.i_isn3  = mk(base + 2);
        qif.i_isn4  = mk(base + 3);
        qif.i_deq   = deq;
        qif.i_flush = fl;
        ndeq = int'(deq[0] && m_count >= 1) + int'(deq == 2'b11 && m_count >= 2);
        @(posedge clk);
        #1;
        if (fl) begin
            m_count = 0;
            exp_q.delete();
        end else begin
            m_count = m_count + nenq - ndeq;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && m_count > 0; i++)
            step4(4'd0, 0, 2'b11, 1'b0);
        step4(4'd0, 0, 2'b00, 1'b0);
        chk("drain_count", qif.o_count, 0);
    endtask

    always @(negedge clk) begin
        if (run && rst_n) begin
            chk("count",   qif.o_count, m_count);
            chk("full",    qif.o_full,  m_count > DEPTH - 4);
            chk("valid",   qif.o_valid, {m_count >= 2, m_count >= 1});
            chk("bound",   qif.o_count <= DEPTH, 1);
            if (m_count < 2) chk("isn2_zero", qif.o_isn2, 0);
            if (m_count < 1) chk("isn1_zero", qif.o_isn1, 0);
            if (!qif.i_flush) begin
                if (qif.i_deq[0] && m_count >= 1)       pop_chk("deq_isn1", qif.o_isn1);
                if (qif.i_deq == 2'b11 && m_count >= 2) pop_chk("deq_isn2", qif.o_isn2);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        bit full_now;
        qif.i_valid = '0; qif.i_deq = '0; qif.i_flush = 1'b0;
        qif.i_isn1 = '0; qif.i_isn2 = '0; qif.i_isn3 = '0; qif.i_isn4 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", qif.o_count, 0);
        chk("rst_valid", qif.o_valid, 0);
        chk("rst_full",  qif.o_full,  0);
`ifdef INSN_QUEUE_STATS_EN
        chk("rst_hwm", hwm, 0);
        chk("rst_fc",  fc,  0);
`endif
        rst_n = 1'b1;
        run   = 1'b1;

        // Full group, visible next cycle
        step4(4'hF, 1, 2'b00, 1'b0);
        chk("t1_isn1",  qif.o_isn1,  mk(1));
        chk("t1_isn2",  qif.o_isn2,  mk(2));
        chk("t1_count", qif.o_count, 4);
        chk("t1_valid", qif.o_valid, 2'b11);
        drain();

        // Sparse mask compaction
        step4(4'b1010, 10, 2'b00, 1'b0);
        chk("t2_isn1",  qif.o_isn1,  mk(11));
        chk("t2_isn2",  qif.o_isn2,  mk(13));
        chk("t2_count", qif.o_count, 2);
        drain();

        // Full threshold
        step4(4'hF, 20, 2'b00, 1'b0);
        step4(4'hF, 24, 2'b00, 1'b0);
        step4(4'hF, 28, 2'b00, 1'b0);
        step4(4'b0001, 32, 2'b00, 1'b0);
        chk("t3_full13", qif.o_full, 1);
        step4(4'hF, 40, 2'b00, 1'b0);
        chk("t3_ignored_count", qif.o_count, 13);
        chk("t3_still_full",    qif.o_full,  1);
`ifdef INSN_QUEUE_STATS_EN
        chk("t3_hwm", hwm, 13);
`endif
        step4(4'd0, 0, 2'b11, 1'b0);
        chk("t3_count11", qif.o_count, 11);
        chk("t3_not_full", qif.o_full, 0);
`ifdef INSN_QUEUE_STATS_EN
        chk("t3_full_cycles", fc, 1);
`endif
        drain();

        // Wrap: 20 groups of 4 through the ring with 2-wide dequeue; upstream holds when full
        acc = 0;
        for (int c = 0; c < 200 && acc < 20; c++) begin
            full_now = m_count > DEPTH - 4;
            step4(4'hF, 100 + 4 * acc, 2'b11, 1'b0);
            if (!full_now) acc++;
        end
        drain();

        // Flush beats enqueue and dequeue
        step4(4'hF, 200, 2'b00, 1'b0);
        step4(4'hF, 204, 2'b00, 1'b0);
        step4(4'b0001, 208, 2'b00, 1'b0);
        chk("t5_count9", qif.o_count, 9);
        step4(4'hF, 212, 2'b11, 1'b1);
        chk("t5_count", qif.o_count, 0);
        chk("t5_valid", qif.o_valid, 0);
        chk("t5_full",  qif.o_full,  0);
        step4(4'd0, 0, 2'b00, 1'b0);
        chk("t5_isn1_zero", qif.o_isn1, 0);

        // Dequeue on empty ignored, enqueue proceeds
        step4(4'b0001, 300, 2'b11, 1'b0);
        chk("t6_count", qif.o_count, 1);
        chk("t6_isn1",  qif.o_isn1,  mk(300));
        drain();

        // Asynchronous reset mid-operation
        step4(4'hF, 400, 2'b00, 1'b0);
        step4(4'd0, 0, 2'b00, 1'b0);
        rst_n = 1'b0;
        #1;
        m_count = 0;
        exp_q.delete();
        chk("rstmid_count", qif.o_count, 0);
        chk("rstmid_valid", qif.o_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step4(4'b0100, 500, 2'b00, 1'b0);
        chk("post_rst_isn1", qif.o_isn1, mk(502));
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/insn_queue.md
Name: insn_queue

Overview:
- In-order instruction queue directly downstream of the aligner in the superscalar MIPS front end.
- Accepts up to 4 aligned instructions per cycle under a sparse valid mask and compacts them in program order into a circular buffer.
- Presents the 2 oldest entries per cycle to the issue stage.
- Generates back-pressure (o_full) to the fetch/align path and supports a single-cycle flush on branch redirect.

Parameters:
- INSN_WIDTH, 99, width of one decoded instruction bundle.
- DEPTH, 16, number of entries; must be a power of 2 and at least 8.
- PTR_WIDTH, 4, log2(DEPTH); width of the head/tail pointers.

Ports:
- i_Clk  in  1  clock.
- i_Reset_n  in  1  reset: asynchronous, active-low.
- i_flush  in  1  discard all contents (branch mispredict/redirect).
- i_valid  in  4  per-slot valid for i_isn1..i_isn4; any pattern is legal.
- i_isn1..i_isn4  in  INSN_WIDTH each  instructions; i_isn1 is oldest.
- o_full  out  1  high when free entries < 4; the upstream stage stalls.
- o_valid  out  2  bit0 = head entry valid, bit1 = head+1 entry valid.
- o_isn1, o_isn2  out  INSN_WIDTH each  head and head+1 entries.
- i_deq  in  2  issue-stage consume mask.
- o_count  out  PTR_WIDTH+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (async assert, sync release):
  - head = 0, tail = 0, count = 0.
  - o_valid = 0, o_full = 0, o_count = 0.
  - Storage array is not reset.
- Compaction: valid slots are packed in order isn1→isn4.
  - nenq = popcount(i_valid).
  - k-th valid slot is written to mem[(tail+k) mod DEPTH].
  - Example: i_valid = 4'b1010 writes isn2 to tail and isn4 to tail+1.
- Enqueue fires when i_valid != 0, o_full = 0 and i_flush = 0.
  - On fire, tail += nenq, modulo DEPTH (wraps naturally).
  - When o_full = 1, inputs are ignored; upstream must hold them.
- o_full = (DEPTH - count) < 4, combinational from registered count.
  - Enqueue gating uses pre-dequeue count (conservative, no same-cycle bypass of freed slots).
- Output side:
  - o_valid[0] = count ≥ 1; o_valid[1] = count ≥ 2.
  - o_isn1 = mem[head], o_isn2 = mem[head+1 mod DEPTH].
  - Each o_isn is forced to 0 when its o_valid bit is low.
- Dequeue: ndeq = i_deq[0] & o_valid[0] + i_deq[1] & i_deq[0] & o_valid[1].
  - i_deq = 2'b10 is treated as no dequeue.
  - Masked bits beyond o_valid are ignored.
  - head += ndeq.
- Count update each cycle: count_next = count + (enq fired ? nenq : 0) - ndeq.
- Latency: an instruction enqueued in cycle N appears on o_isn in cycle N+1 at the earliest (no write-to-read bypass).
- Empty queue: o_valid = 0, i_deq ignored; a simultaneous enqueue still proceeds.
- Full-threshold queue: a dequeue in the same cycle does not enable that cycle's enqueue; o_full drops the next cycle.
- Flush: has priority over enqueue and dequeue.
  - Next cycle: head = tail = count = 0, o_valid = 0.
  - The same-cycle enqueue is dropped.
- Reset asserted mid-operation: immediate return to reset values, contents lost.
- Occupancy never exceeds DEPTH, guaranteed by o_full gating; the bench asserts count ≤ DEPTH.

Optional Feature:
- Macro INSN_QUEUE_STATS_EN.
- Defined: adds outputs o_hwm (PTR_WIDTH+1) and o_full_cycles (32).
  - o_hwm: highest occupancy seen since reset. Flush does not clear it.
  - o_full_cycles: counts cycles with o_full = 1 and i_valid != 0. Saturates at 2^32-1.
  - Both reset to 0.
- Undefined: neither port nor register exists; the core behaviour is identical.

Decomposition:
- Shared package mips_pkg:
  - INSN_WIDTH, ISSUE_WIDTH = 2, FETCH_WIDTH = 4.
  - Instruction bundle typedef insn_t.
  - Popcount function for a 4-bit mask.
- Sub-module insn_compact: combinational; maps i_valid plus the 4 instructions to packed slots 0..3, slot-valid mask and nenq.
- The queue keeps the storage, pointers and counters.

Test Plan:
1. Reset then i_valid = 4'hF with isn1..4 = A,B,C,D → next cycle o_valid = 2'b11, o_isn1 = A, o_isn2 = B, o_count = 4.
2. Sparse mask 4'b1010 (B, D), i_deq = 0 → entries stored contiguously; o_isn1 = B, o_isn2 = D, o_count = 2.
3. Fill to 13 with no dequeue → o_full = 1. Further i_valid = 4'hF is ignored, count stays 13. Then i_deq = 2'b11 for one cycle → count 11, o_full = 0.
4. Wrap: 20 enqueues of 4 interleaved with dequeues of 2 → output order matches the input sequence exactly across the DEPTH boundary.
5. i_flush with count = 9, simultaneous i_valid = 4'hF and i_deq = 2'b11 → next cycle count = 0, o_valid = 0, o_full = 0.
6. Queue empty, i_deq = 2'b11 with enqueue of one instruction E → count = 1; o_isn1 = E the following cycle.
